// File: rtl/frame_scaler_pipe.sv
// Integer-factor upscaler: SRC frame buffer centred on a DST raster with border fill; coordinates in to colour out in RAM_LAT+1 pixel_ce cycles.
// No backpressure: every register, counter and delay stage advances only on pixel_ce and holds otherwise.
module frame_scaler_pipe #(
    parameter int SRC_W   = 320,
    parameter int SRC_H   = 240,
    parameter int SCALE   = 2,
    parameter int DST_W   = 800,
    parameter int DST_H   = 600,
    parameter int H_OFF   = (DST_W - SRC_W * SCALE) / 2,
    parameter int V_OFF   = (DST_H - SRC_H * SCALE) / 2,
    parameter int ADDR_W  = 17,
    parameter int RAM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pixel_ce,
    input  logic [9:0]        pixel_x,
    input  logic [9:0]        pixel_y,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              de_in,
    input  logic [11:0]       border_rgb,
    output logic [ADDR_W-1:0] fb_read_addr,
    input  logic [11:0]       fb_read_data,
    output logic [3:0]        color_r,
    output logic [3:0]        color_g,
    output logic [3:0]        color_b,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic              de_out
);

    localparam logic [10:0]       X_LO     = 11'(H_OFF);
    localparam logic [10:0]       X_HI     = 11'(H_OFF + SRC_W * SCALE);
    localparam logic [10:0]       Y_LO     = 11'(V_OFF);
    localparam logic [10:0]       Y_HI     = 11'(V_OFF + SRC_H * SCALE);
    localparam logic [9:0]        X_LAST   = 10'(DST_W - 1);
    localparam logic [1:0]        REP_MAX  = 2'(SCALE - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(SRC_W);
    localparam int                DL       = (RAM_LAT > 0) ? RAM_LAT : 1;

    if (64'(SRC_W) * 64'(SRC_H) > (64'd1 << ADDR_W)) begin : g_addr_w_too_small
        $error("frame_scaler_pipe: ADDR_W cannot address SRC_W*SRC_H pixels");
    end
    if (SCALE < 1 || SCALE > 4) begin : g_bad_scale
        $error("frame_scaler_pipe: SCALE must be 1..4");
    end
    if (RAM_LAT < 0 || RAM_LAT > 3) begin : g_bad_ram_lat
        $error("frame_scaler_pipe: RAM_LAT must be 0..3");
    end

    logic              x_in, y_in, win, line_end, frame_start;
    logic [1:0]        x_rep_q, x_rep_d, y_rep_q, y_rep_d;
    logic [ADDR_W-1:0] col_q, col_d, row_base_q, row_base_d;
    logic [3:0]        dly_q [DL];
    logic [3:0]        dly_d [DL];
    logic [3:0]        stage_in, stage_out;
    logic [11:0]       rgb_q, rgb_d;
    logic [2:0]        sync_q, sync_d;

    assign x_in        = ({1'b0, pixel_x} >= X_LO) && ({1'b0, pixel_x} < X_HI);
    assign y_in        = ({1'b0, pixel_y} >= Y_LO) && ({1'b0, pixel_y} < Y_HI);
    assign win         = x_in && y_in;
    assign line_end    = (pixel_x == X_LAST);
    assign frame_start = (pixel_x == 10'd0) && (pixel_y == 10'd0);

    assign fb_read_addr = win ? (row_base_q + col_q) : '0;

    // Column state also clears at line end so a window spanning the full raster width restarts each line.
    always_comb begin
        x_rep_d    = x_rep_q;
        col_d      = col_q;
        y_rep_d    = y_rep_q;
        row_base_d = row_base_q;
        if (pixel_ce) begin
            if (win && !line_end) begin
                if (x_rep_q == REP_MAX) begin
                    x_rep_d = 2'd0;
                    col_d   = col_q + ADDR_W'(1);
                end else begin
                    x_rep_d = x_rep_q + 2'd1;
                end
            end else begin
                x_rep_d = 2'd0;
                col_d   = '0;
            end
            if (frame_start) begin
                row_base_d = '0;
                y_rep_d    = 2'd0;
            end else if (line_end && y_in) begin
                if (y_rep_q == REP_MAX) begin
                    y_rep_d    = 2'd0;
                    row_base_d = row_base_q + ROW_STEP;
                end else begin
                    y_rep_d = y_rep_q + 2'd1;
                end
            end
        end
    end

    assign stage_in  = {win, hsync_in, vsync_in, de_in};
    assign stage_out = (RAM_LAT == 0) ? stage_in : dly_q[DL-1];

    always_comb begin
        dly_d = dly_q;
        if (pixel_ce) begin
            dly_d[0] = stage_in;
            for (int i = 1; i < DL; i++) begin
                dly_d[i] = dly_q[i-1];
            end
        end
    end

    // Border is taken at output time; only the window flag travels with the read latency.
    always_comb begin
        rgb_d  = rgb_q;
        sync_d = sync_q;
        if (pixel_ce) begin
            rgb_d  = stage_out[3] ? fb_read_data : border_rgb;
            sync_d = stage_out[2:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_rep_q    <= 2'd0;
            y_rep_q    <= 2'd0;
            col_q      <= '0;
            row_base_q <= '0;
            rgb_q      <= 12'd0;
            sync_q     <= 3'd0;
            for (int i = 0; i < DL; i++) begin
                dly_q[i] <= 4'd0;
            end
        end else begin
            x_rep_q    <= x_rep_d;
            y_rep_q    <= y_rep_d;
            col_q      <= col_d;
            row_base_q <= row_base_d;
            rgb_q      <= rgb_d;
            sync_q     <= sync_d;
            for (int i = 0; i < DL; i++) begin
                dly_q[i] <= dly_d[i];
            end
        end
    end

    assign {color_r, color_g, color_b}     = rgb_q;
    assign {hsync_out, vsync_out, de_out}  = sync_q;

endmodule

// File: tb/tb_frame_scaler_pipe.sv
// Four scaler configurations share one raster stream; each is checked against an arithmetic window/address model.
module tb_frame_scaler_pipe;

    typedef struct {
        int          inst;
        int          frame;
        int          x;
        int          y;
        int          addr;
        bit          chk;
        logic [11:0] rgb;
    } vec_t;

    typedef struct {
        int          inst;
        int          due;
        logic [11:0] rgb;
    } pend_t;

    typedef struct {
        bit          win [4];
        bit          ok [4];
        int          addr [4];
        bit          hs;
        bit          vs;
        bit          de;
        logic [11:0] bd;
    } rec_t;

    int c_srcw  [4] = '{320, 160, 320, 800};
    int c_srch  [4] = '{240, 120, 240, 600};
    int c_scale [4] = '{2, 3, 2, 1};
    int c_lat   [4] = '{1, 0, 2, 3};

    logic        clk = 1'b0;
    logic        reset_n, ce, hs, vs, de;
    logic [9:0]  px, py;
    logic [11:0] border;
    logic [16:0] addr_a, addr_b, addr_c;
    logic [18:0] addr_d;
    logic [31:0] addr_i [4];
    logic [11:0] rd [4];
    logic [11:0] rpipe [4][3];
    logic [3:0]  cr [4], cg [4], cb [4];
    logic        hso [4], vso [4], deo [4];

    int    vectors = 0;
    int    errors  = 0;
    int    n       = 0;
    int    n_rst   = 0;
    int    cur_frame = 0;
    bit    rnd_border = 1'b0;
    bit    synced [4];
    bit    full_line [600];
    rec_t  hist [8];
    vec_t  tbl [$];
    pend_t pending [$];

    always #5 clk = ~clk;

    frame_scaler_pipe u_a (
        .clk(clk), .reset_n(reset_n), .pixel_ce(ce), .pixel_x(px), .pixel_y(py),
        .hsync_in(hs), .vsync_in(vs), .de_in(de), .border_rgb(border),
        .fb_read_addr(addr_a), .fb_read_data(rd[0]),
        .color_r(cr[0]), .color_g(cg[0]), .color_b(cb[0]),
        .hsync_out(hso[0]), .vsync_out(vso[0]), .de_out(deo[0]));

    frame_scaler_pipe #(.SRC_W(160), .SRC_H(120), .SCALE(3), .RAM_LAT(0)) u_b (
        .clk(clk), .reset_n(reset_n), .pixel_ce(ce), .pixel_x(px), .pixel_y(py),
        .hsync_in(hs), .vsync_in(vs), .de_in(de), .border_rgb(border),
        .fb_read_addr(addr_b), .fb_read_data(rd[1]),
        .color_r(cr[1]), .color_g(cg[1]), .color_b(cb[1]),
        .hsync_out(hso[1]), .vsync_out(vso[1]), .de_out(deo[1]));

    frame_scaler_pipe #(.RAM_LAT(2)) u_c (
        .clk(clk), .reset_n(reset_n), .pixel_ce(ce), .pixel_x(px), .pixel_y(py),
        .hsync_in(hs), .vsync_in(vs), .de_in(de), .border_rgb(border),
        .fb_read_addr(addr_c), .fb_read_data(rd[2]),
        .color_r(cr[2]), .color_g(cg[2]), .color_b(cb[2]),
        .hsync_out(hso[2]), .vsync_out(vso[2]), .de_out(deo[2]));

    frame_scaler_pipe #(.SRC_W(800), .SRC_H(600), .SCALE(1), .ADDR_W(19), .RAM_LAT(3)) u_d (
        .clk(clk), .reset_n(reset_n), .pixel_ce(ce), .pixel_x(px), .pixel_y(py),
        .hsync_in(hs), .vsync_in(vs), .de_in(de), .border_rgb(border),
        .fb_read_addr(addr_d), .fb_read_data(rd[3]),
        .color_r(cr[3]), .color_g(cg[3]), .color_b(cb[3]),
        .hsync_out(hso[3]), .vsync_out(vso[3]), .de_out(deo[3]));

    assign addr_i[0] = 32'(addr_a);
    assign addr_i[1] = 32'(addr_b);
    assign addr_i[2] = 32'(addr_c);
    assign addr_i[3] = 32'(addr_d);

    function automatic logic [11:0] hash(input logic [31:0] a);
        logic [31:0] t;
        t = a * 32'd40503 + (a >> 3) + 32'h5A5;
        return t[11:0] ^ t[23:12];
    endfunction

    // Frame-buffer contents are hash(addr); the read pipe is clock-enabled by pixel_ce.
    always @(posedge clk) begin
        if (ce) begin
            for (int i = 0; i < 4; i++) begin
                rpipe[i][2] <= rpipe[i][1];
                rpipe[i][1] <= rpipe[i][0];
                rpipe[i][0] <= hash(addr_i[i]);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            rd[i] = hash(addr_i[i]);
            if (c_lat[i] > 0) rd[i] = rpipe[i][c_lat[i] - 1];
        end
    end

    function automatic int hoff(input int i);
        return (800 - c_srcw[i] * c_scale[i]) / 2;
    endfunction

    function automatic int voff(input int i);
        return (600 - c_srch[i] * c_scale[i]) / 2;
    endfunction

    function automatic bit exp_win(input int i, input int x, input int y);
        return x >= hoff(i) && x < hoff(i) + c_srcw[i] * c_scale[i] &&
               y >= voff(i) && y < voff(i) + c_srch[i] * c_scale[i];
    endfunction

    function automatic int exp_addr(input int i, input int x, input int y);
        if (!exp_win(i, x, y)) return 0;
        return ((y - voff(i)) / c_scale[i]) * c_srcw[i] + (x - hoff(i)) / c_scale[i];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < 4; i++) begin
            logic [11:0] ec;
            logic [2:0]  es;
            bit          skip;
            int          m;
            skip = 1'b0;
            if (n == n_rst) begin
                ec = 12'd0;
                es = 3'd0;
            end else begin
                m  = n - 1 - c_lat[i];
                ec = hist[(n - 1) % 8].bd;
                es = 3'd0;
                if (m >= n_rst) begin
                    es = {hist[m % 8].hs, hist[m % 8].vs, hist[m % 8].de};
                    if (hist[m % 8].win[i]) begin
                        if (hist[m % 8].ok[i]) ec = hash(hist[m % 8].addr[i]);
                        else skip = 1'b1;
                    end
                end
            end
            chk($sformatf("sync%0d n=%0d", i, n), 32'({hso[i], vso[i], deo[i]}), 32'(es));
            if (!skip) chk($sformatf("rgb%0d n=%0d", i, n), 32'({cr[i], cg[i], cb[i]}), 32'(ec));
        end
        for (int k = pending.size() - 1; k >= 0; k--) begin
            if (n - 1 == pending[k].due) begin
                chk($sformatf("tbl_rgb%0d due=%0d", pending[k].inst, pending[k].due),
                    32'({cr[pending[k].inst], cg[pending[k].inst], cb[pending[k].inst]}),
                    32'(pending[k].rgb));
                pending.delete(k);
            end
        end
    endtask

    task automatic px_cycle(input bit cev, input int x, input int y, input bit full);
        bit   w [4];
        bit   ok [4];
        int   a [4];
        rec_t rc;
        @(negedge clk);
        ce = cev;
        px = 10'(x);
        py = 10'(y);
        if (cev) begin
            hs     = 1'($urandom);
            vs     = 1'($urandom);
            de     = 1'($urandom);
            border = rnd_border ? 12'($urandom) : 12'h0F0;
        end
        #1;
        for (int i = 0; i < 4; i++) begin
            w[i]  = exp_win(i, x, y);
            a[i]  = exp_addr(i, x, y);
            ok[i] = full && synced[i];
            if (!w[i] || ok[i]) chk($sformatf("addr%0d (%0d,%0d)", i, x, y), addr_i[i], 32'(a[i]));
        end
        if (cev) begin
            foreach (tbl[k]) begin
                if (tbl[k].frame == cur_frame && tbl[k].x == x && tbl[k].y == y) begin
                    chk($sformatf("tbl_addr%0d (%0d,%0d)", tbl[k].inst, x, y),
                        addr_i[tbl[k].inst], 32'(tbl[k].addr));
                    if (tbl[k].chk)
                        pending.push_back(pend_t'{tbl[k].inst, n + c_lat[tbl[k].inst], tbl[k].rgb});
                end
            end
        end
        @(posedge clk);
        if (cev) begin
            rc.win  = w;
            rc.ok   = ok;
            rc.addr = a;
            rc.hs   = hs;
            rc.vs   = vs;
            rc.de   = de;
            rc.bd   = border;
            hist[n % 8] = rc;
            n++;
            if (x == 0 && y == 0) synced = '{1'b1, 1'b1, 1'b1, 1'b1};
        end
        #1;
        check_outputs();
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        ce      = 1'b0;
        reset_n = 1'b0;
        n_rst   = n;
        synced  = '{1'b0, 1'b0, 1'b0, 1'b0};
        #1;
        check_outputs();
        repeat (2) @(negedge clk);
        #1;
        check_outputs();
        reset_n = 1'b1;
    endtask

    task automatic run_frame(input int f, input bit rnd_b, input bit do_rst, input int last_y);
        cur_frame  = f;
        rnd_border = rnd_b;
        for (int y = 0; y <= last_y; y++) begin
            if (full_line[y]) begin
                for (int x = 0; x < 800; x++) begin
                    if ($urandom_range(7) == 0) px_cycle(1'b0, x, y, 1'b1);
                    px_cycle(1'b1, x, y, 1'b1);
                    if (do_rst && y == 300 && x == 400) pulse_reset();
                end
            end else begin
                if (y == 0) px_cycle(1'b1, 0, 0, 1'b0);
                px_cycle(1'b1, 799, y, 1'b0);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        ce      = 1'b0;
        px      = 10'd0;
        py      = 10'd0;
        hs      = 1'b0;
        vs      = 1'b0;
        de      = 1'b0;
        border  = 12'h0F0;
        synced  = '{1'b1, 1'b1, 1'b1, 1'b1};

        tbl.push_back(vec_t'{0, 1, 80, 60, 0, 1'b1, hash(0)});
        tbl.push_back(vec_t'{0, 1, 81, 60, 0, 1'b0, 12'h000});
        tbl.push_back(vec_t'{0, 1, 82, 60, 1, 1'b0, 12'h000});
        tbl.push_back(vec_t'{0, 1, 719, 539, 76799, 1'b1, hash(76799)});
        tbl.push_back(vec_t'{0, 1, 79, 60, 0, 1'b1, 12'h0F0});
        tbl.push_back(vec_t'{0, 1, 720, 60, 0, 1'b1, 12'h0F0});
        tbl.push_back(vec_t'{0, 1, 80, 59, 0, 1'b1, 12'h0F0});
        tbl.push_back(vec_t'{0, 1, 80, 540, 0, 1'b1, 12'h0F0});
        tbl.push_back(vec_t'{0, 1, 80, 61, 0, 1'b0, 12'h000});
        tbl.push_back(vec_t'{0, 1, 80, 62, 320, 1'b0, 12'h000});
        tbl.push_back(vec_t'{0, 3, 80, 60, 0, 1'b1, hash(0)});
        tbl.push_back(vec_t'{1, 1, 160, 121, 0, 1'b0, 12'h000});
        tbl.push_back(vec_t'{1, 1, 160, 123, 160, 1'b0, 12'h000});
        tbl.push_back(vec_t'{1, 1, 159, 120, 0, 1'b1, 12'h0F0});
        tbl.push_back(vec_t'{1, 1, 160, 120, 0, 1'b1, hash(0)});
        tbl.push_back(vec_t'{2, 1, 80, 62, 320, 1'b0, 12'h000});
        tbl.push_back(vec_t'{2, 1, 719, 539, 76799, 1'b1, hash(76799)});
        tbl.push_back(vec_t'{3, 1, 0, 0, 0, 1'b0, 12'h000});
        tbl.push_back(vec_t'{3, 1, 799, 0, 799, 1'b0, 12'h000});
        tbl.push_back(vec_t'{3, 1, 123, 300, 240123, 1'b0, 12'h000});
        tbl.push_back(vec_t'{3, 1, 799, 599, 479999, 1'b1, hash(479999)});

        repeat (3) @(negedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        reset_n = 1'b1;

        foreach (full_line[y]) full_line[y] = 1'b0;
        foreach (tbl[k]) if (tbl[k].frame == 1) full_line[tbl[k].y] = 1'b1;
        full_line[0]   = 1'b1;
        full_line[119] = 1'b1;
        full_line[479] = 1'b1;
        full_line[599] = 1'b1;
        full_line[$urandom_range(599)] = 1'b1;
        full_line[$urandom_range(599)] = 1'b1;
        run_frame(1, 1'b0, 1'b0, 599);

        foreach (full_line[y]) full_line[y] = 1'b0;
        full_line[300] = 1'b1;
        full_line[$urandom_range(599)] = 1'b1;
        full_line[$urandom_range(599)] = 1'b1;
        run_frame(2, 1'b1, 1'b1, 599);

        foreach (full_line[y]) full_line[y] = 1'b0;
        full_line[0]  = 1'b1;
        full_line[60] = 1'b1;
        full_line[61] = 1'b1;
        full_line[62] = 1'b1;
        run_frame(3, 1'b1, 1'b0, 62);

        foreach (pending[k]) begin
            vectors++;
            errors++;
            $display("FAIL tbl_rgb%0d due=%0d: got no output, want 0x%0h", pending[k].inst, pending[k].due, pending[k].rgb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
